// File: rtl/ahb_lite_mst_if.sv
// AHB-Lite bus bundle between a single master and its slave side.
//   master modport: drives address/control/write data, receives HREADY/HRESP/HRDATA
//   slave  modport: mirror image of master
interface ahb_lite_mst_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [63:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_mst.sv
// AHB-Lite single-transfer master fed by a command FIFO.
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake; cmd_write/addr/size/wdata payload
//   rsp_valid/rdata/err    : one-cycle response pulse per command, in order
//   busy                   : work queued, on the bus, or a response being presented
//   ahb                    : AHB-Lite master side (NONSEQ/IDLE only, SINGLE bursts)
module ahb_lite_mst #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [31:0]    cmd_addr,
    input  logic [2:0]     cmd_size,
    input  logic [63:0]    cmd_wdata,
    output logic           rsp_valid,
    output logic [63:0]    rsp_rdata,
    output logic           rsp_err,
    output logic           busy,
    ahb_lite_mst_if.master ahb
);
    localparam int unsigned AW = $clog2(CMD_DEPTH);

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
    } cmd_t;

    // Address-phase state doubles as the HTRANS encoding.
    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_NONSEQ = 2'b10
    } trans_e;

    cmd_t        fifo_q [CMD_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;

    trans_e      trans_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [63:0] aph_wdata_q;
    logic [63:0] hwdata_q;
    logic        dph_vld_q, dph_write_q;
    logic        rsp_valid_q, rsp_err_q;
    logic [63:0] rsp_rdata_q;

    logic        empty, full, push, pop, cancel, fwd, nonempty_d;
    cmd_t        cmd_in, head_d;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // Head leaves the FIFO only when its address phase is accepted.
    assign pop       = (trans_q == TR_NONSEQ) && ahb.HREADY;
    // First ERROR cycle: drop the pending address phase, command stays queued.
    assign cancel    = dph_vld_q && ahb.HRESP && !ahb.HREADY;

    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    assign nonempty_d = (wr_ptr_d != rd_ptr_d);

    assign cmd_in = {cmd_write, cmd_addr, cmd_size, cmd_wdata};
    // The entry being written this edge is not in the array yet; forward it
    // when it becomes the new head so it goes out on the very next cycle.
    assign fwd    = push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
    assign head_d = fwd ? cmd_in : fifo_q[rd_ptr_d[AW-1:0]];

    always_ff @(posedge HCLK) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= cmd_in;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trans_q     <= TR_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            aph_wdata_q <= '0;
            hwdata_q    <= '0;
            dph_vld_q   <= 1'b0;
            dph_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;

            // Address phase: while stalled the head is unchanged, so reloading
            // it keeps HADDR/control stable; IDLE leaves them holding.
            if (cancel || !nonempty_d) begin
                trans_q <= TR_IDLE;
            end else begin
                trans_q     <= TR_NONSEQ;
                haddr_q     <= head_d.addr;
                hwrite_q    <= head_d.write;
                hsize_q     <= head_d.size;
                aph_wdata_q <= head_d.wdata;
            end

            // Data phase: one HREADY edge both retires the current data phase
            // and promotes the accepted address phase.
            if (ahb.HREADY) begin
                dph_vld_q <= pop;
                if (pop) begin
                    dph_write_q <= hwrite_q;
                    if (hwrite_q) hwdata_q <= aph_wdata_q;
                end
            end

            rsp_valid_q <= dph_vld_q && ahb.HREADY;
            if (dph_vld_q && ahb.HREADY) begin
                rsp_rdata_q <= dph_write_q ? 64'h0 : ahb.HRDATA;
                rsp_err_q   <= ahb.HRESP;
            end
        end
    end

    assign ahb.HTRANS = trans_q;
    assign ahb.HADDR  = haddr_q;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HSIZE  = hsize_q;
    assign ahb.HBURST = 3'b000;
    assign ahb.HPROT  = HPROT_VAL;
    assign ahb.HWDATA = hwdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = !empty || dph_vld_q || rsp_valid_q;
endmodule
